glitch_filter_bank: RTL and testbench

GLITCH_FILTER_BANK -- requirements
Module: glitch_filter_bank

---
 rtl/glitch_filter_bank.sv | 173 +++++++++++++++++
 tb/tb_glitch_filter_bank.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_filter_bank.sv
`timescale 1ns/1ps
// glitch_filter_bank
// N-channel input conditioner: each raw input is synchronized, then passed
// through a per-channel debounce filter whose window and edge selection are
// software-programmable. Output changes raise sticky status flags that feed
// one aggregated interrupt. All control goes through a byte-wide register
// port with a registered read path.
module glitch_filter_bank #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  localparam int NSR        = (N + 7) / 8,
  localparam int ADDR_W     = $clog2(N + NSR + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              acc_en_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o,
  input  logic [N-1:0]      data_in,
  output logic [N-1:0]      data_out,
  output logic              int_o
);

  // Register map: CFG[i] at i, STAT[k] at N+k, GCTRL right after STAT.
  localparam logic [31:0] STAT_BASE  = 32'(N);
  localparam logic [31:0] GCTRL_ADDR = 32'(N + NSR);

  // Synchronizer chain; stage 0 samples the raw pin.
  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;

  // Per-channel configuration and filter state.
  logic [7:0]   cfg_q [N];
  logic [7:0]   cfg_d [N];
  logic [4:0]   cnt_q [N];
  logic [4:0]   cnt_d [N];
  logic [N-1:0] out_q, out_d;

  // Sticky event flags, one bit per channel.
  logic [N-1:0] stat_q, stat_d;

  // Global control, interrupt and read data.
  logic         en_q, en_d;
  logic         mode_q, mode_d;
  logic         int_q, int_d;
  logic [7:0]   rdata_q, rdata_d;

  // Decoded access and filter helpers.
  logic [31:0]  addr_ext;
  logic         rd_stb;
  logic         wr_stb;
  logic         gctrl_wr;
  logic [N-1:0] cfg_wr;
  logic [N-1:0] w1c;
  logic [N-1:0] s;
  logic [N-1:0] event_v;
  logic [7:0]   rd_val;

  assign addr_ext = 32'(addr_i);
  assign rd_stb   = acc_en_i & ~wr_en_i;
  assign wr_stb   = acc_en_i &  wr_en_i;
  assign s        = sync_q[SYNC_STAGES-1];

  // Shift the synchronizer chain every cycle, independent of the enable.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], data_in};
  end

  // Decode writes: CFG select, STAT write-one-to-clear mask, GCTRL select.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    cfg_wr   = '0;
    w1c      = '0;
    gctrl_wr = 1'b0;
    for (int i = 0; i < N; i++) begin
      cfg_wr[i] = wr_stb && (addr_ext == 32'(i));
      w1c[i]    = wr_stb && (addr_ext == STAT_BASE + 32'(i / 8)) && wdata_i[i[2:0]];
    end
    gctrl_wr = wr_stb && (addr_ext == GCTRL_ADDR);
  end

  // Read mux; unmapped addresses and STAT bits beyond N return zero.
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (addr_ext == 32'(i)) begin
        rd_val = cfg_q[i];
      end
      if (addr_ext == STAT_BASE + 32'(i / 8)) begin
        rd_val[i[2:0]] = stat_q[i];
      end
    end
    if (addr_ext == GCTRL_ADDR) begin
      rd_val = {6'b0, mode_q, en_q};
    end
  end

  // Per-channel debounce: an edge selected by FMODE must persist for WIN+1
  // cycles before it reaches the output; unselected edges pass immediately.
  always_comb begin
    out_d   = out_q;
    event_v = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!en_q || (s[i] == out_q[i])) begin
        cnt_d[i] = 5'd0;
      end else if ((s[i] ? cfg_q[i][0] : cfg_q[i][1]) && (cnt_q[i] < cfg_q[i][7:3])) begin
        cnt_d[i] = cnt_q[i] + 5'd1;
      end else begin
        out_d[i] = s[i];
        cnt_d[i] = 5'd0;
      end
      // Reprogramming a channel restarts its count; the new window takes
      // effect from the following edge.
      if (cfg_wr[i]) begin
        cnt_d[i] = 5'd0;
      end
      event_v[i] = (out_d[i] != out_q[i]) && cfg_q[i][2];
    end
  end

  // Register file, sticky status and interrupt generation.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cfg_d[i] = cfg_wr[i] ? wdata_i : cfg_q[i];
    end
    en_d    = gctrl_wr ? wdata_i[0] : en_q;
    mode_d  = gctrl_wr ? wdata_i[1] : mode_q;
    // A new event on the same edge as a clear of that bit keeps it set.
    stat_d  = (stat_q & ~w1c) | event_v;
    // Pulse mode flags only 0->1 transitions of STAT, so simultaneous sets
    // merge into one pulse; level mode follows the registered flags.
    int_d   = mode_q ? |(stat_d & ~stat_q) : |stat_q;
    rdata_d = rd_stb ? rd_val : rdata_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      out_q   <= '0;
      stat_q  <= '0;
      en_q    <= 1'b0;
      mode_q  <= 1'b0;
      int_q   <= 1'b0;
      rdata_q <= 8'h00;
      // NOTE: the CFG/cnt arrays are software-visible registers, not RAM, so they are reset element by element like any other flop.
      for (int i = 0; i < N; i++) begin
        cfg_q[i] <= 8'h00;
        cnt_q[i] <= 5'd0;
      end
    end else begin
      // NOTE: all state updates use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
      sync_q  <= sync_d;
      out_q   <= out_d;
      stat_q  <= stat_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      int_q   <= int_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < N; i++) begin
        cfg_q[i] <= cfg_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_out = out_q;
  assign rdata_o  = rdata_q;
  assign int_o    = int_q;

endmodule

// File: tb/tb_glitch_filter_bank.sv
`timescale 1ns/1ps
// Self-checking bench for glitch_filter_bank with N=8, SYNC_STAGES=2.
// A behavioural model tracks every edge; directed sequences add explicit
// latency and status expectations, and a random phase stresses the rest.
module tb_glitch_filter_bank;

  localparam int N  = 8;
  localparam int SS = 2;
  localparam int AW = 4;
  localparam logic [3:0] STAT_A  = 4'd8;
  localparam logic [3:0] GCTRL_A = 4'd9;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          acc_en_i;
  logic          wr_en_i;
  logic [AW-1:0] addr_i;
  logic [7:0]    wdata_i;
  logic [7:0]    rdata_o;
  logic [N-1:0]  data_in;
  logic [N-1:0]  data_out;
  logic          int_o;

  int n_checks = 0;
  int n_errors = 0;

  glitch_filter_bank #(.N(N), .SYNC_STAGES(SS)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .acc_en_i (acc_en_i),
    .wr_en_i  (wr_en_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .data_in  (data_in),
    .data_out (data_out),
    .int_o    (int_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  bit [7:0]     m_cfg [N];
  int           m_run [N];   // consecutive enabled edges with s != out
  bit [N-1:0]   m_stat;
  bit [N-1:0]   m_out;
  bit           m_en, m_mode, m_int;
  bit [7:0]     m_rdata;
  bit [N-1:0]   m_hist [$];  // m_hist[k] = data_in sampled k+1 edges ago

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cfg[i] = 8'h00;
      m_run[i] = 0;
    end
    m_stat = '0; m_out = '0; m_en = 1'b0; m_mode = 1'b0; m_int = 1'b0;
    m_rdata = 8'h00;
    m_hist.delete();
    for (int k = 0; k < SS; k++) m_hist.push_back('0);
  endfunction

  function automatic bit [7:0] model_reg(input int a);
    if (a < N)      return m_cfg[a];
    if (a == N)     return m_stat;
    if (a == N + 1) return {6'b0, m_mode, m_en};
    return 8'h00;
  endfunction

  function automatic void model_step();
    bit [N-1:0] s, next_out, ev, old_stat;
    bit         old_mode;
    int         a, limit;
    if (rst_i) begin
      model_reset();
      return;
    end
    a        = int'(addr_i);
    s        = m_hist[SS-1];
    old_stat = m_stat;
    old_mode = m_mode;
    if (acc_en_i && !wr_en_i) m_rdata = model_reg(a);
    next_out = m_out;
    ev       = '0;
    for (int i = 0; i < N; i++) begin
      if (m_en && (s[i] != m_out[i])) begin
        limit = ((s[i] && m_cfg[i][0]) || (!s[i] && m_cfg[i][1])) ? int'(m_cfg[i][7:3]) : 0;
        m_run[i]++;
        if (m_run[i] > limit) begin
          next_out[i] = s[i];
          m_run[i]    = 0;
          ev[i]       = m_cfg[i][2];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_out = next_out;
    m_hist.push_front(data_in);
    void'(m_hist.pop_back());
    if (acc_en_i && wr_en_i) begin
      if (a < N) begin
        m_cfg[a] = wdata_i;
        m_run[a] = 0;
      end else if (a == N) begin
        m_stat = m_stat & ~wdata_i;
      end else if (a == N + 1) begin
        m_en   = wdata_i[0];
        m_mode = wdata_i[1];
      end
    end
    m_stat = m_stat | ev;
    m_int  = old_mode ? |(m_stat & ~old_stat) : |old_stat;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge: advance the model alongside the DUT, then compare.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model data_out", 32'(data_out), 32'(m_out));
    check("model int_o",    32'(int_o),    32'(m_int));
    check("model rdata_o",  32'(rdata_o),  32'(m_rdata));
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    acc_en_i = 1'b1; wr_en_i = 1'b1; addr_i = a; wdata_i = d;
    tick();
    acc_en_i = 1'b0; wr_en_i = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
    acc_en_i = 1'b1; wr_en_i = 1'b0; addr_i = a;
    tick();
    acc_en_i = 1'b0;
    d = rdata_o;
  endtask

  // Count edges until data_out[ch] reaches val; 0 means the budget expired.
  task automatic edges_until(input int ch, input bit val, input int budget, output int n);
    n = 0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (data_out[ch] == val) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    logic [7:0] v;
    int         lat, cnt;
    bit         seen;

    rst_i = 1'b1; acc_en_i = 1'b0; wr_en_i = 1'b0;
    addr_i = '0; wdata_i = '0; data_in = '0;

    // Register table: reset reads of the whole map, then write/readback.
    for (int a = 0; a <= N + 1; a++) vecs.push_back('{1'b0, 4'(a), 8'h00, 8'h00});
    vecs.push_back('{1'b1, 4'd0,  8'hA5, 8'h00});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 8'hA5});
    vecs.push_back('{1'b1, 4'd7,  8'h5A, 8'h00});
    vecs.push_back('{1'b0, 4'd7,  8'h00, 8'h5A});
    vecs.push_back('{1'b1, 4'd9,  8'hFF, 8'h00});
    vecs.push_back('{1'b0, 4'd9,  8'h00, 8'h03});
    vecs.push_back('{1'b1, 4'd12, 8'hFF, 8'h00});
    vecs.push_back('{1'b0, 4'd12, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 4'd8,  8'hFF, 8'h00});
    vecs.push_back('{1'b0, 4'd8,  8'h00, 8'h00});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 8'hA5});
    vecs.push_back('{1'b1, 4'd0,  8'h00, 8'h00});
    vecs.push_back('{1'b1, 4'd7,  8'h00, 8'h00});
    vecs.push_back('{1'b1, 4'd9,  8'h00, 8'h00});
    vecs.push_back('{1'b0, 4'd9,  8'h00, 8'h00});

    // Reset held for two cycles.
    tick(); tick();
    rst_i = 1'b0;
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset int_o",    32'(int_o),    32'h0);
    check("reset rdata_o",  32'(rdata_o),  32'h0);

    foreach (vecs[j]) begin
      if (vecs[j].wr) begin
        reg_write(vecs[j].addr, vecs[j].wdata);
      end else begin
        reg_read(vecs[j].addr, v);
        check($sformatf("table read addr %0d", vecs[j].addr), 32'(v), 32'(vecs[j].exp));
      end
    end

    // Glitch reject on ch0: FMODE=11, INT_EN=1, WIN=3.
    reg_write(4'd0, 8'h1F);
    reg_write(GCTRL_A, 8'h01);
    data_in[0] = 1'b1;
    repeat (3) tick();
    data_in[0] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (data_out[0]) seen = 1'b1;
    end
    check("ch0 short pulse rejected", 32'(seen), 32'h0);
    data_in[0] = 1'b1;
    edges_until(0, 1'b1, 12, lat);
    check("ch0 rise latency", 32'(lat), 32'd6);
    reg_read(STAT_A, v);
    check("STAT after ch0 event", 32'(v), 32'h01);
    check("level int after ch0", 32'(int_o), 32'h1);
    repeat (4) tick();
    data_in[0] = 1'b0;
    repeat (8) tick();
    reg_write(STAT_A, 8'hFF);
    reg_write(4'd0, 8'h00);
    tick();
    check("int clear after W1C", 32'(int_o), 32'h0);

    // Asymmetric filter on ch1: rising filtered with WIN=7, falling passes.
    reg_write(4'd1, 8'h3D);
    data_in[1] = 1'b1;
    edges_until(1, 1'b1, 16, lat);
    check("ch1 rise latency", 32'(lat), 32'd10);
    repeat (3) tick();
    data_in[1] = 1'b0;
    edges_until(1, 1'b0, 16, lat);
    check("ch1 fall latency", 32'(lat), 32'd3);
    reg_write(STAT_A, 8'hFF);
    tick();

    // W1C collision on ch2 (unfiltered, INT_EN=1): out changes on edge 3.
    reg_write(4'd2, 8'h04);
    data_in[2] = 1'b1;
    tick(); tick();
    reg_write(STAT_A, 8'h04);
    check("ch2 out on collision edge", 32'(data_out[2]), 32'h1);
    reg_read(STAT_A, v);
    check("STAT set wins over W1C", 32'(v), 32'h04);
    check("level int asserted", 32'(int_o), 32'h1);
    reg_write(STAT_A, 8'h04);
    check("int still high on clear edge", 32'(int_o), 32'h1);
    tick();
    check("level int drops next cycle", 32'(int_o), 32'h0);
    reg_read(STAT_A, v);
    check("STAT bit2 cleared", 32'(v), 32'h00);

    // Pulse mode: simultaneous ch3/ch4 events give a single pulse.
    reg_write(GCTRL_A, 8'h03);
    reg_write(4'd3, 8'h04);
    reg_write(4'd4, 8'h04);
    data_in[3] = 1'b1;
    data_in[4] = 1'b1;
    cnt = 0;
    repeat (16) begin
      tick();
      if (int_o) cnt++;
    end
    check("pulse count", 32'(cnt), 32'd1);
    reg_write(GCTRL_A, 8'h01);
    reg_read(STAT_A, v);
    check("STAT kept across MODE write", 32'(v), 32'h18);
    check("level int after mode switch", 32'(int_o), 32'h1);
    reg_write(STAT_A, 8'hFF);
    tick();

    // Reset in the middle of a long count on ch5 (WIN=20).
    reg_write(4'd5, 8'hA7);
    data_in[5] = 1'b1;
    repeat (12) tick();
    check("ch5 still counting", 32'(data_out[5]), 32'h0);
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    check("mid-count reset data_out", 32'(data_out), 32'h0);
    check("mid-count reset int_o",    32'(int_o),    32'h0);
    check("mid-count reset rdata_o",  32'(rdata_o),  32'h0);
    for (int a = 0; a <= N + 1; a++) begin
      reg_read(4'(a), v);
      check($sformatf("post-reset reg %0d", a), 32'(v), 32'h0);
    end
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (data_out != '0) seen = 1'b1;
    end
    check("data_out frozen while EN=0", 32'(seen), 32'h0);
    reg_write(GCTRL_A, 8'h01);
    tick(); tick();
    check("unfiltered after enable", 32'(data_out), 32'h3C);

    // Random phase: slowly toggling inputs and random register traffic.
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) data_in[i] = ~data_in[i];
      end
      acc_en_i = ($urandom_range(0, 2) == 0);
      wr_en_i  = 1'($urandom_range(0, 1));
      addr_i   = 4'($urandom_range(0, 15));
      wdata_i  = 8'($urandom);
      if (wr_en_i && (addr_i < 4'(N)) && ($urandom_range(0, 3) != 0))
        wdata_i[7:3] = 5'($urandom_range(0, 6));
      if (wr_en_i && (addr_i == GCTRL_A))
        wdata_i[0] = ($urandom_range(0, 3) != 0);
      rst_i = ($urandom_range(0, 799) == 0);
      tick();
    end
    acc_en_i = 1'b0;
    rst_i    = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
